// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch and load/store ports.
// Data port wins ties; fetches can be flushed; a watchdog aborts hung accesses.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    input  logic          if_flush_i,
    output logic [DW-1:0] if_rdata_o,
    output logic          if_ack_o,
    input  logic          dm_req_i,
    input  logic          dm_we_i,
    input  logic [AW-1:0] dm_addr_i,
    input  logic [DW-1:0] dm_wdata_i,
    input  logic [2:0]    dm_type_i,
    output logic [DW-1:0] dm_rdata_o,
    output logic          dm_ack_o,
    output logic          bus_err_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic [2:0]    mem_type_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_ready_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM,
        DRAIN
    } state_t;

    // Counter only needs to reach TIMEOUT-1; the edge after that aborts.
    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
    localparam logic [2:0] TYPE_WORD = 3'b010;

    state_t        state_q, state_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]    mem_type_q, mem_type_d;
    logic          if_ack_q, if_ack_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic          dm_ack_q, dm_ack_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          bus_err_q, bus_err_d;
    logic          wd_hit;

    assign wd_hit = (wdog_q == WD_LAST);

    // State, watchdog and every registered output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wdog_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_type_q  <= '0;
            if_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_ack_q    <= 1'b0;
            dm_rdata_q  <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wdog_q      <= wdog_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_type_q  <= mem_type_d;
            if_ack_q    <= if_ack_d;
            if_rdata_q  <= if_rdata_d;
            dm_ack_q    <= dm_ack_d;
            dm_rdata_q  <= dm_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Next-state: grant, completion, flush and watchdog abort.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_type_d  = mem_type_q;
        if_ack_d    = 1'b0;
        if_rdata_d  = '0;
        dm_ack_d    = 1'b0;
        dm_rdata_d  = '0;
        bus_err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (dm_req_i) begin
                    state_d     = BUSY_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                    mem_type_d  = dm_type_i;
                end else if (if_req_i && !if_flush_i) begin
                    state_d     = BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = '0;
                    mem_type_d  = TYPE_WORD;
                end
            end
            BUSY_IF: begin
                if (mem_ready_i) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!if_flush_i) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata_i;
                    end
                end else if (wd_hit) begin
                    // A flush coinciding with the abort cancels the ack.
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!if_flush_i) begin
                        if_ack_d  = 1'b1;
                        bus_err_d = 1'b1;
                    end
                end else if (if_flush_i) begin
                    state_d = DRAIN;
                end
            end
            BUSY_DM: begin
                if (mem_ready_i) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    dm_ack_d   = 1'b1;
                    dm_rdata_d = mem_we_q ? '0 : mem_rdata_i;
                end else if (wd_hit) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    dm_ack_d  = 1'b1;
                    bus_err_d = 1'b1;
                end
            end
            DRAIN: begin
                if (mem_ready_i || wd_hit) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase

        if (state_d != state_q) begin
            wdog_d = '0;
        end else if (state_q != IDLE && !mem_ready_i) begin
            wdog_d = wdog_q + 1'b1;
        end else begin
            wdog_d = wdog_q;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_type_o  = mem_type_q;
    assign if_ack_o    = if_ack_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_ack_o    = dm_ack_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: scoreboard of expected acks, transaction-level
// model of latency, flush and watchdog outcomes, randomized accesses.
module tb_mem_port_arbiter;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_flush = 1'b0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [2:0]  dm_type = '0;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_type;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(T)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
        .if_rdata_o(if_rdata), .if_ack_o(if_ack),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr),
        .dm_wdata_i(dm_wdata), .dm_type_i(dm_type),
        .dm_rdata_o(dm_rdata), .dm_ack_o(dm_ack), .bus_err_o(bus_err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_type_o(mem_type),
        .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: every ack pops the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (if_ack || dm_ack) begin
                chk("ack_both", 64'(if_ack & dm_ack), 0);
                if (sb.size() == 0) begin
                    chk("unexpected_ack", {62'd0, if_ack, dm_ack}, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ack_port", 64'(dm_ack), 64'(e.port));
                    chk("ack_rdata", dm_ack ? dm_rdata : if_rdata, e.rdata);
                    chk("ack_bus_err", 64'(bus_err), 64'(e.err));
                end
            end else begin
                chk("bus_err_no_ack", 64'(bus_err), 0);
            end
        end
    end

    // One access. port: 1=data, 0=fetch. d: cycles of mem_req before
    // mem_ready (>=T never completes). f: busy cycle of a flush pulse, -1 none.
    task automatic run_txn(input bit port, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] typ, input int d, input int f,
                           input bit iflush, input logic [31:0] rdat);
        int   hi;
        int   w;
        bit   flushed;
        exp_t e;
        flushed = !port && (f >= 0);
        if (!flushed) begin
            hi = (d < T) ? d + 1 : T;
            e.port  = port;
            e.err   = (d >= T);
            e.rdata = (d >= T || (port && we)) ? 32'd0 : rdat;
            sb.push_back(e);
        end else if (f == d) begin
            hi = d + 1;
        end else if (f == T - 1) begin
            hi = T;
        end else begin
            hi = ((d < f + T) ? d : f + T) + 1;
        end
        @(negedge clk);
        if (port) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr;
            dm_wdata = wdata; dm_type = typ;
        end else begin
            if_req = 1'b1; if_addr = addr;
            if (iflush) begin
                if_flush = 1'b1;
                @(negedge clk);
                chk("idle_flush_block", 64'(mem_req), 0);
                if_flush = 1'b0;
            end
        end
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!mem_req && w < 8);
        chk("grant_latency", 64'(w), 1);
        if (!mem_req) begin
            if_req = 1'b0; dm_req = 1'b0;
            sb.delete();
            return;
        end
        for (int k = 0; k < hi; k++) begin
            chk("mem_req_held", 64'(mem_req), 1);
            chk("mem_addr", mem_addr, addr);
            chk("mem_we", 64'(mem_we), 64'(port & we));
            chk("mem_type", 64'(mem_type), port ? 64'(typ) : 64'(3'b010));
            if (port && we) chk("mem_wdata", mem_wdata, wdata);
            mem_ready = (k == d);
            mem_rdata = (k == d) ? rdat : $urandom;
            if_flush  = (k == f);
            if (k == f && !port) if_req = 1'b0;
            @(negedge clk);
        end
        chk("mem_req_drop", 64'(mem_req), 0);
        mem_ready = 1'b0; if_flush = 1'b0;
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);
        #1;
        chk("ack_missing", 64'(sb.size()), 0);
        sb.delete();
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_mem_req", 64'(mem_req), 0);
        chk("rst_if_ack", 64'(if_ack), 0);
        chk("rst_dm_ack", 64'(dm_ack), 0);
        chk("rst_bus_err", 64'(bus_err), 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        // Minimum-latency fetch
        run_txn(0, 0, 32'h100, 0, 3'b010, 0, -1, 0, 32'h00500093);

        // Store and fetch contend; store first
        @(negedge clk);
        sb.push_back('{1'b1, 32'd0, 1'b0});
        sb.push_back('{1'b0, 32'h13572468, 1'b0});
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000;
        dm_wdata = 32'hDEADBEEF; dm_type = 3'b010;
        if_req = 1'b1; if_addr = 32'h300;
        @(negedge clk);
        chk("cont_mem_req", 64'(mem_req), 1);
        chk("cont_mem_we", 64'(mem_we), 1);
        chk("cont_mem_addr", mem_addr, 32'h2000);
        chk("cont_mem_wdata", mem_wdata, 32'hDEADBEEF);
        mem_ready = 1'b1; mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        chk("cont_dm_ack", 64'(dm_ack), 1);
        dm_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("cont_if_grant", 64'(mem_req), 1);
        chk("cont_if_addr", mem_addr, 32'h300);
        chk("cont_if_we", 64'(mem_we), 0);
        mem_ready = 1'b1; mem_rdata = 32'h13572468;
        @(negedge clk);
        chk("cont_if_ack", 64'(if_ack), 1);
        if_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("cont_sb_empty", 64'(sb.size()), 0);
        sb.delete();

        // Flush while busy, then a normal fetch
        run_txn(0, 0, 32'h180, 0, 0, 3, 0, 0, 32'h11111111);
        run_txn(0, 0, 32'h200, 0, 0, 1, -1, 0, 32'h22222222);

        // Load timeout
        run_txn(1, 0, 32'h4000, 0, 3'b010, 100, -1, 0, 32'h33333333);

        // Flush while idle blocks the grant one edge
        run_txn(0, 0, 32'h240, 0, 0, 0, -1, 1, 32'h44444444);

        // Reset mid-load
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h5000; dm_type = 3'b100;
        @(negedge clk);
        chk("rst_mid_busy", 64'(mem_req), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_req", 64'(mem_req), 0);
        chk("rst_async_addr", mem_addr, 0);
        chk("rst_async_type", 64'(mem_type), 0);
        chk("rst_async_ack", {62'd0, if_ack, dm_ack}, 0);
        dm_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_txn(1, 0, 32'h5004, 0, 3'b100, 2, -1, 0, 32'h66666666);

        // Random accesses
        for (int n = 0; n < 80; n++) begin
            bit port;
            int d;
            int f;
            int fmax;
            port = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 5) == 0) ? 100 : int'($urandom_range(0, 5));
            fmax = (d < T - 1) ? d : T - 1;
            f = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, fmax)) : -1;
            run_txn(port, 1'($urandom_range(0, 1)), $urandom, $urandom,
                    3'($urandom_range(0, 7)), d, f,
                    !port && ($urandom_range(0, 3) == 0), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
